reg_writeback: RTL and testbench

Write-back unit that drives the single write port of the register file (RegWEn, rd, write_data). It merges single-cycle ALU results with in-order, variable-latency load responses from the data-memory interface, buffers a load that collides with an ALU write, and tracks destination registers of outstanding loads in a scoreboard. Decode uses the scoreboard to stall RAW/WAW hazards.

---
 rtl/reg_writeback.sv | 165 ++++++++++++++++
 tb/tb_reg_writeback.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file write-back: arbitrates ALU results, a one-entry load skid buffer
// and in-order load responses onto the single write port, and tracks outstanding load destinations.
//
// Handshakes: a load issue is taken on a cycle where ld_issue && ld_issue_ready.
// A load response is taken on a cycle where ld_rsp_valid && ld_rsp_ready.
// ld_issue_ready depends on registered state only. ld_rsp_ready also depends on alu_valid.
// alu_valid is never stalled.
module reg_writeback #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  output logic            ld_issue_ready,
  input  logic            ld_rsp_valid,
  input  logic [XLEN-1:0] ld_rsp_data,
  output logic            ld_rsp_ready,
  output logic            RegWEn,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending,
  output logic            ld_rsp_err
);

  localparam int PW = $clog2(LDQ_DEPTH);

  // Tag FIFO of load destinations, pointers carry one extra wrap bit
  logic [4:0]      tag_q [LDQ_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]     wr_ptr_d, rd_ptr_d;
  logic [PW:0]     fifo_count;
  logic            fifo_empty, fifo_full;
  logic [4:0]      head_rd;

  logic            skid_valid_q, skid_valid_d;
  logic [4:0]      skid_rd_q, skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;

  logic            wen_q, wen_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            push, rsp_hs, rsp_acc, rsp_orphan;
  logic            skid_load, skid_drain;
  logic            win_valid;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [31:0]     pending_v;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_rd    = tag_q[rd_ptr_q[PW-1:0]];

  assign ld_issue_ready = !fifo_full;
  assign ld_rsp_ready   = !skid_valid_q || !alu_valid;

  assign push       = ld_issue && !fifo_full;
  assign rsp_hs     = ld_rsp_valid && ld_rsp_ready;
  assign rsp_acc    = rsp_hs && !fifo_empty;
  assign rsp_orphan = rsp_hs && fifo_empty;

  // An accepted response loses to the ALU or to an older skid entry.
  assign skid_load  = rsp_acc && (alu_valid || skid_valid_q);
  assign skid_drain = !alu_valid && skid_valid_q;

  assign wr_ptr_d = push    ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = rsp_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign err_d    = err_q | rsp_orphan;

  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end else if (skid_valid_q) begin
      win_valid = 1'b1;
      win_rd    = skid_rd_q;
      win_data  = skid_data_q;
    end else if (rsp_acc) begin
      win_valid = 1'b1;
      win_rd    = head_rd;
      win_data  = ld_rsp_data;
    end
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (skid_load) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = head_rd;
      skid_data_d  = ld_rsp_data;
    end else if (skid_drain) begin
      skid_valid_d = 1'b0;
    end
  end

  // x0 winners still consume their slot but never assert the write enable.
  always_comb begin
    wen_d   = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (win_valid) begin
      wen_d   = (win_rd != 5'd0);
      rd_d    = win_rd;
      wdata_d = win_data;
    end
  end

  always_comb begin
    logic [PW-1:0] offset;
    pending_v = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q[PW-1:0];
      if ({1'b0, offset} < fifo_count) pending_v[tag_q[i]] = 1'b1;
    end
    if (skid_valid_q) pending_v[skid_rd_q] = 1'b1;
    pending_v[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LDQ_DEPTH; i++) tag_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      wen_q        <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (push) tag_q[wr_ptr_q[PW-1:0]] <= ld_issue_rd;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  assign RegWEn     = wen_q;
  assign rd         = rd_q;
  assign write_data = wdata_q;
  assign pending    = pending_v;
  assign ld_rsp_err = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed plus random bench for reg_writeback.
// Checks run against a queue-based reference model of outstanding loads, the skid and the write port.
module tb_reg_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_issue_ready;
  logic            ld_rsp_valid;
  logic [XLEN-1:0] ld_rsp_data;
  logic            ld_rsp_ready;
  logic            RegWEn;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pending;
  logic            ld_rsp_err;

  reg_writeback #(.XLEN(XLEN), .LDQ_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .ld_issue_ready(ld_issue_ready),
    .ld_rsp_valid  (ld_rsp_valid),
    .ld_rsp_data   (ld_rsp_data),
    .ld_rsp_ready  (ld_rsp_ready),
    .RegWEn        (RegWEn),
    .rd            (rd),
    .write_data    (write_data),
    .pending       (pending),
    .ld_rsp_err    (ld_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: outstanding load destinations, skid entry, write port, error flag
  logic [4:0]  m_ldq[$];
  logic        m_skv;
  logic [4:0]  m_skrd;
  logic [31:0] m_skd;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_err;

  int total;
  int passed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_ldq[i]) p[m_ldq[i]] = 1'b1;
    if (m_skv) p[m_skrd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_ldq.delete();
    m_skv  = 1'b0;
    m_skrd = '0;
    m_skd  = '0;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_wd   = '0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_wen"},   {31'd0, RegWEn}, {31'd0, m_wen});
    check({tag, "_rd"},    {27'd0, rd}, {27'd0, m_rd});
    check({tag, "_wdata"}, write_data, m_wd);
    check({tag, "_pend"},  pending, exp_pending());
    check({tag, "_iss_rdy"}, {31'd0, ld_issue_ready}, {31'd0, (m_ldq.size() < DEPTH)});
    check({tag, "_rsp_rdy"}, {31'd0, ld_rsp_ready}, {31'd0, (!m_skv || !alu_valid)});
    check({tag, "_err"},   {31'd0, ld_rsp_err}, {31'd0, m_err});
  endtask

  // One clock: drive inputs, check against model, advance model across the edge.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ir,
                       input logic rv, input logic [31:0] rdat);
    logic rr, acc, orphan, push;
    logic [4:0] hrd;
    logic n_wen, n_skv;
    logic [4:0] n_rd, n_skrd;
    logic [31:0] n_wd, n_skd;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_issue = iv; ld_issue_rd = ir;
    ld_rsp_valid = rv; ld_rsp_data = rdat;
    #2;
    check_outputs("cyc");
    rr     = !m_skv || !av;
    acc    = rv && rr && (m_ldq.size() > 0);
    orphan = rv && rr && (m_ldq.size() == 0);
    push   = iv && (m_ldq.size() < DEPTH);
    hrd    = acc ? m_ldq[0] : 5'd0;
    n_wen = 1'b0; n_rd = m_rd; n_wd = m_wd;
    n_skv = m_skv; n_skrd = m_skrd; n_skd = m_skd;
    if (av) begin
      n_wen = (ar != 0); n_rd = ar; n_wd = ad;
      if (acc) begin n_skv = 1'b1; n_skrd = hrd; n_skd = rdat; end
    end else if (m_skv) begin
      n_wen = (m_skrd != 0); n_rd = m_skrd; n_wd = m_skd;
      n_skv = acc;
      if (acc) begin n_skrd = hrd; n_skd = rdat; end
    end else if (acc) begin
      n_wen = (hrd != 0); n_rd = hrd; n_wd = rdat;
    end
    @(posedge clk);
    #1;
    if (acc) void'(m_ldq.pop_front());
    if (push) m_ldq.push_back(ir);
    if (orphan) m_err = 1'b1;
    m_wen = n_wen; m_rd = n_rd; m_wd = n_wd;
    m_skv = n_skv; m_skrd = n_skrd; m_skd = n_skd;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_rsp_valid = 1'b0; ld_rsp_data = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic av, iv, rv;
    logic [4:0] ar, ir;
    logic [31:0] ad, rdat;
    total = 0;
    passed = 0;
    rst_n = 1'b1;
    #3;
    do_reset();

    // ALU write, then idle
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0);
    check("alu_wen", {31'd0, RegWEn}, 32'd1);
    check("alu_rd", {27'd0, rd}, 32'd5);
    check("alu_data", write_data, 32'hDEADBEEF);
    idle();
    check("alu_idle_wen", {31'd0, RegWEn}, 32'd0);

    // Three loads, two to the same register
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h11);
    check("ld1_rd", {27'd0, rd}, 32'd3);
    check("ld1_data", write_data, 32'h11);
    check("ld1_p3", {31'd0, pending[3]}, 32'd1);
    check("ld1_p7", {31'd0, pending[7]}, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h22);
    check("ld2_rd", {27'd0, rd}, 32'd7);
    check("ld2_data", write_data, 32'h22);
    check("ld2_p7", {31'd0, pending[7]}, 32'd0);
    check("ld2_p3", {31'd0, pending[3]}, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h33);
    check("ld3_rd", {27'd0, rd}, 32'd3);
    check("ld3_data", write_data, 32'h33);
    check("ld3_p3", {31'd0, pending[3]}, 32'd0);
    idle();

    // Load collides with ALU
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 32'd0);
    cycle(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b1, 32'hAA);
    check("col_alu_rd", {27'd0, rd}, 32'd9);
    check("col_alu_data", write_data, 32'h55);
    check("col_p4", {31'd0, pending[4]}, 32'd1);
    idle();
    check("col_ld_wen", {31'd0, RegWEn}, 32'd1);
    check("col_ld_rd", {27'd0, rd}, 32'd4);
    check("col_ld_data", write_data, 32'hAA);
    check("col_p4_clr", {31'd0, pending[4]}, 32'd0);

    // Backpressure: skid full while ALU stays valid
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0, 32'd0);
    cycle(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b1, 32'hB1);
    alu_valid = 1'b1;
    #1;
    check("bp_ready", {31'd0, ld_rsp_ready}, 32'd0);
    cycle(1'b1, 5'd10, 32'h2, 1'b0, 5'd0, 1'b1, 32'hB2);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hB2);
    check("bp_skid_rd", {27'd0, rd}, 32'd12);
    check("bp_skid_data", write_data, 32'hB1);
    idle();
    check("bp_ld2_rd", {27'd0, rd}, 32'd13);
    check("bp_ld2_data", write_data, 32'hB2);

    // Fill the tag FIFO
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + i), 1'b0, 32'd0);
    check("full_not_ready", {31'd0, ld_issue_ready}, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 1'b1, 32'hC0);
    check("full_ready_again", {31'd0, ld_issue_ready}, 32'd1);
    check("full_p20", {31'd0, pending[20]}, 32'd0);
    check("full_p21", {31'd0, pending[21]}, 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'(32'hC1 + i));
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      av   = ($urandom_range(0, 3) == 0);
      ar   = 5'($urandom_range(0, 31));
      ad   = $urandom;
      iv   = 1'($urandom_range(0, 1));
      ir   = 5'($urandom_range(0, 31));
      rv   = (m_ldq.size() > 0) && ($urandom_range(0, 1) == 1);
      rdat = $urandom;
      cycle(av, ar, ad, iv, ir, rv, rdat);
    end
    for (int n = 0; n < 40; n++) begin
      if (m_ldq.size() == 0 && !m_skv) break;
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, (m_ldq.size() > 0), $urandom);
    end
    idle();
    check("rand_drain_pend", pending, 32'd0);

    // x0 load and ALU
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0);
    check("x0_p0_issued", {31'd0, pending[0]}, 32'd0);
    cycle(1'b1, 5'd0, 32'h123, 1'b0, 5'd0, 1'b1, 32'h77);
    check("x0_alu_wen", {31'd0, RegWEn}, 32'd0);
    check("x0_p0_skid", {31'd0, pending[0]}, 32'd0);
    idle();
    check("x0_ld_wen", {31'd0, RegWEn}, 32'd0);
    check("x0_fifo_empty", {31'd0, ld_issue_ready}, 32'd1);

    // Response with nothing outstanding
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h99);
    check("orphan_err", {31'd0, ld_rsp_err}, 32'd1);
    check("orphan_wen", {31'd0, RegWEn}, 32'd0);
    idle();
    idle();
    check("orphan_err_sticky", {31'd0, ld_rsp_err}, 32'd1);

    // Reset with three loads outstanding and the skid full
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + i), 1'b0, 32'd0);
    cycle(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 1'b1, 32'hD1);
    check("pre_rst_pend", {31'd0, (pending != 32'd0)}, 32'd1);
    do_reset();
    check("post_rst_pend", pending, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hE1);
    check("late_rsp_err", {31'd0, ld_rsp_err}, 32'd1);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
